// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter and sequencer shared by the IF-stage
// fetch and the MEM-stage load/store. It runs one bus transaction at a time,
// and a data access wins over a fetch. A flushed fetch drains on the bus
// without returning data.
//
// Ports:
//   i_clk, i_rst_n       clock; asynchronous active-low reset
//   i_flush              pipeline flush (affects fetches only)
//   i_inst_*, o_inst_*   fetch request/address, fetched word and done pulse
//   i_data_*, o_data_*   load/store request, controls, load data and done pulse
//   o_bus_*, i_bus_*     SRAM-style bus: req/we/sel/addr/wdata out, ack/rdata in
//   o_stallreq_if/_mem   per-stage stall requests (combinational)
//   o_bus_err            timeout pulse (tied 0 without the timeout feature)
//
// Build option: define MEM_ARB_TIMEOUT_EN to abort a transaction that has
// waited TIMEOUT cycles for i_bus_ack.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_inst_req,
  input  logic [31:0] i_inst_addr,
  output logic [31:0] o_inst_rdata,
  output logic        o_inst_done,
  input  logic        i_data_req,
  input  logic        i_data_we,
  input  logic [3:0]  i_data_sel,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic [31:0] o_data_rdata,
  output logic        o_data_done,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [3:0]  o_bus_sel,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata,
  output logic        o_stallreq_if,
  output logic        o_stallreq_mem,
  output logic        o_bus_err
);

  typedef enum logic [1:0] {StIdle, StInst, StData, StDrop} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic        r_bus_we;
  logic [3:0]  r_bus_sel;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;
  logic        r_inst_done;
  logic        r_data_done;
  logic        r_bus_err;

  logic        w_grant_inst;
  logic        w_grant_data;
  logic        w_inst_done;
  logic        w_data_done;
  logic        w_err;
  logic        w_timeout;
  logic [31:0] w_ack_rdata;

  // Data returned with a done pulse; a timed-out access returns 0.
  assign w_ack_rdata = i_bus_ack ? i_bus_rdata : 32'h0;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;

  // Fires on the cycle the wait counter would reach TIMEOUT.
  assign w_timeout = o_bus_req && !i_bus_ack && (r_cnt == 8'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 8'h0;
    end else if (w_grant_inst || w_grant_data) begin
      r_cnt <= 8'h0;
    end else if (o_bus_req && !i_bus_ack) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_grant_inst = 1'b0;
    w_grant_data = 1'b0;
    w_inst_done  = 1'b0;
    w_data_done  = 1'b0;
    w_err        = 1'b0;
    unique case (r_state)
      StIdle: begin
        // No grant in a done cycle, so a requester still high there cannot retrigger.
        if (!r_inst_done && !r_data_done) begin
          if (i_data_req) begin
            w_grant_data = 1'b1;
            w_state_next = StData;
          end else if (i_inst_req && !i_flush) begin
            w_grant_inst = 1'b1;
            w_state_next = StInst;
          end
        end
      end
      StInst: begin
        if (i_bus_ack || w_timeout) begin
          w_state_next = StIdle;
          w_inst_done  = !i_flush;
          w_err        = w_timeout;
        end else if (i_flush) begin
          w_state_next = StDrop;
        end
      end
      StData: begin
        if (i_bus_ack || w_timeout) begin
          w_state_next = StIdle;
          w_data_done  = 1'b1;
          w_err        = w_timeout;
        end
      end
      StDrop: begin
        if (i_bus_ack || w_timeout) begin
          w_state_next = StIdle;
          w_err        = w_timeout;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_bus_we     <= 1'b0;
      r_bus_sel    <= 4'h0;
      r_bus_addr   <= 32'h0;
      r_bus_wdata  <= 32'h0;
      r_inst_rdata <= 32'h0;
      r_data_rdata <= 32'h0;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_inst_done <= w_inst_done;
      r_data_done <= w_data_done;
      r_bus_err   <= w_err;
      if (w_grant_data) begin
        r_bus_we    <= i_data_we;
        r_bus_sel   <= i_data_sel;
        r_bus_addr  <= i_data_addr;
        r_bus_wdata <= i_data_wdata;
      end else if (w_grant_inst) begin
        r_bus_we    <= 1'b0;
        r_bus_sel   <= 4'hF;
        r_bus_addr  <= i_inst_addr;
        r_bus_wdata <= 32'h0;
      end
      if (w_inst_done) begin
        r_inst_rdata <= w_ack_rdata;
      end
      if (w_data_done) begin
        r_data_rdata <= r_bus_we ? 32'h0 : w_ack_rdata;
      end
    end
  end

  assign o_bus_req      = (r_state != StIdle);
  assign o_bus_we       = r_bus_we;
  assign o_bus_sel      = r_bus_sel;
  assign o_bus_addr     = r_bus_addr;
  assign o_bus_wdata    = r_bus_wdata;
  assign o_inst_rdata   = r_inst_rdata;
  assign o_inst_done    = r_inst_done;
  assign o_data_rdata   = r_data_rdata;
  assign o_data_done    = r_data_done;
  assign o_bus_err      = r_bus_err;
  assign o_stallreq_if  = i_inst_req & ~r_inst_done;
  assign o_stallreq_mem = i_data_req & ~r_data_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change and outputs are sampled at the
// falling edge; "cycle n" below is the clock period whose falling edge is n.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_done;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_done;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        stallreq_if;
  logic        stallreq_mem;
  logic        bus_err;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(4)) u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_flush        (flush),
    .i_inst_req     (inst_req),
    .i_inst_addr    (inst_addr),
    .o_inst_rdata   (inst_rdata),
    .o_inst_done    (inst_done),
    .i_data_req     (data_req),
    .i_data_we      (data_we),
    .i_data_sel     (data_sel),
    .i_data_addr    (data_addr),
    .i_data_wdata   (data_wdata),
    .o_data_rdata   (data_rdata),
    .o_data_done    (data_done),
    .o_bus_req      (bus_req),
    .o_bus_we       (bus_we),
    .o_bus_sel      (bus_sel),
    .o_bus_addr     (bus_addr),
    .o_bus_wdata    (bus_wdata),
    .i_bus_ack      (bus_ack),
    .i_bus_rdata    (bus_rdata),
    .o_stallreq_if  (stallreq_if),
    .o_stallreq_mem (stallreq_mem),
    .o_bus_err      (bus_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge, where inputs are updated.
  task automatic cyc();
    @(negedge clk);
  endtask

  // Let combinational outputs settle after input changes before sampling.
  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_sel = 4'h0; data_addr = 32'h0;
    data_wdata = 32'h0; bus_ack = 1'b0; bus_rdata = 32'h0;

    // Reset state
    cyc(); settle();
    check_eq("rst_bus_req", {31'h0, bus_req}, 32'h0);
    check_eq("rst_bus_sel", {28'h0, bus_sel}, 32'h0);
    check_eq("rst_inst_rdata", inst_rdata, 32'h0);
    check_eq("rst_done", {30'h0, inst_done, data_done}, 32'h0);
    cyc(); rst_n = 1'b1;
    cyc();

    // Fetch: request c0, ack c2, done c3
    cyc(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; settle();
    check_eq("f_c0_stall_if", {31'h0, stallreq_if}, 32'h1);
    check_eq("f_c0_bus_req", {31'h0, bus_req}, 32'h0);
    cyc(); settle();
    check_eq("f_c1_bus_req", {31'h0, bus_req}, 32'h1);
    check_eq("f_c1_bus_addr", bus_addr, 32'hBFC0_0000);
    check_eq("f_c1_bus_sel_we", {27'h0, bus_sel, bus_we}, {27'h0, 4'hF, 1'b0});
    cyc(); bus_ack = 1'b1; bus_rdata = 32'h3C01_0001; settle();
    check_eq("f_c2_stall_if", {31'h0, stallreq_if}, 32'h1);
    cyc(); bus_ack = 1'b0; settle();
    check_eq("f_c3_inst_done", {31'h0, inst_done}, 32'h1);
    check_eq("f_c3_inst_rdata", inst_rdata, 32'h3C01_0001);
    check_eq("f_c3_stall_if", {31'h0, stallreq_if}, 32'h0);
    check_eq("f_c3_bus_req", {31'h0, bus_req}, 32'h0);
    // inst_req still high through the done cycle: no retrigger
    cyc(); settle();
    check_eq("f_c4_no_retrigger", {31'h0, bus_req}, 32'h0);
    check_eq("f_c4_done_pulse", {31'h0, inst_done}, 32'h0);
    inst_req = 1'b0;
    cyc();

    // Priority: fetch and load together, data goes first
    cyc(); inst_req = 1'b1; inst_addr = 32'h0040_0000;
    data_req = 1'b1; data_we = 1'b0; data_sel = 4'hF; data_addr = 32'h8000_0010; settle();
    check_eq("p_c0_stalls", {30'h0, stallreq_if, stallreq_mem}, 32'h3);
    cyc(); settle();
    check_eq("p_c1_bus_addr", bus_addr, 32'h8000_0010);
    check_eq("p_c1_bus_we", {31'h0, bus_we}, 32'h0);
    bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
    cyc(); bus_ack = 1'b0; settle();
    check_eq("p_c2_data_done", {31'h0, data_done}, 32'h1);
    check_eq("p_c2_data_rdata", data_rdata, 32'h1111_2222);
    check_eq("p_c2_stalls", {30'h0, stallreq_if, stallreq_mem}, 32'h2);
    check_eq("p_c2_inst_done", {31'h0, inst_done}, 32'h0);
    data_req = 1'b0;
    cyc(); settle();
    check_eq("p_c3_no_grant_in_done", {31'h0, bus_req}, 32'h0);
    check_eq("p_c3_stall_if", {31'h0, stallreq_if}, 32'h1);
    cyc(); settle();
    check_eq("p_c4_bus_req", {31'h0, bus_req}, 32'h1);
    check_eq("p_c4_bus_addr", bus_addr, 32'h0040_0000);
    bus_ack = 1'b1; bus_rdata = 32'h2222_3333;
    cyc(); bus_ack = 1'b0; settle();
    check_eq("p_c5_inst_done", {31'h0, inst_done}, 32'h1);
    check_eq("p_c5_inst_rdata", inst_rdata, 32'h2222_3333);
    inst_req = 1'b0;
    cyc();

    // Flush two cycles into a fetch; ack four cycles after the flush
    cyc(); inst_req = 1'b1; inst_addr = 32'h0040_0100;
    cyc(); settle();
    check_eq("fl_c1_bus_req", {31'h0, bus_req}, 32'h1);
    cyc(); flush = 1'b1; inst_addr = 32'h0040_0200;
    cyc(); flush = 1'b0;
    for (int i = 3; i <= 5; i++) begin
      settle();
      check_eq($sformatf("fl_c%0d_drop_bus_req", i), {31'h0, bus_req}, 32'h1);
      check_eq($sformatf("fl_c%0d_drop_addr", i), bus_addr, 32'h0040_0100);
      check_eq($sformatf("fl_c%0d_no_done", i), {31'h0, inst_done}, 32'h0);
      cyc();
    end
    bus_ack = 1'b1; bus_rdata = 32'hDEAD_0000; settle();
    check_eq("fl_c6_bus_req", {31'h0, bus_req}, 32'h1);
    cyc(); bus_ack = 1'b0; settle();
    check_eq("fl_c7_idle", {31'h0, bus_req}, 32'h0);
    check_eq("fl_c7_no_done", {31'h0, inst_done}, 32'h0);
    check_eq("fl_c7_rdata_kept", inst_rdata, 32'h2222_3333);
    cyc(); settle();
    check_eq("fl_c8_refetch", {31'h0, bus_req}, 32'h1);
    check_eq("fl_c8_refetch_addr", bus_addr, 32'h0040_0200);
    // Flush together with ack: data discarded, no done
    flush = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
    cyc(); flush = 1'b0; bus_ack = 1'b0; settle();
    check_eq("fl_ack_no_done", {31'h0, inst_done}, 32'h0);
    check_eq("fl_ack_idle", {31'h0, bus_req}, 32'h0);
    inst_req = 1'b0;
    cyc();

    // Store: controls latched and held until ack, rdata 0 at done
    cyc(); data_req = 1'b1; data_we = 1'b1; data_sel = 4'b0011;
    data_addr = 32'h8000_0020; data_wdata = 32'hDEAD_BEEF;
    cyc(); data_wdata = 32'h0; data_sel = 4'hF; settle();
    check_eq("st_c1_we_sel", {27'h0, bus_sel, bus_we}, {27'h0, 4'b0011, 1'b1});
    check_eq("st_c1_wdata", bus_wdata, 32'hDEAD_BEEF);
    cyc(); bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF; settle();
    check_eq("st_c2_wdata_stable", bus_wdata, 32'hDEAD_BEEF);
    check_eq("st_c2_addr_stable", bus_addr, 32'h8000_0020);
    cyc(); bus_ack = 1'b0; settle();
    check_eq("st_c3_data_done", {31'h0, data_done}, 32'h1);
    check_eq("st_c3_data_rdata", data_rdata, 32'h0);
    check_eq("st_c3_bus_err", {31'h0, bus_err}, 32'h0);
    data_req = 1'b0;
    cyc();

    // Reset while a load is in DATA
    cyc(); data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8000_0030;
    cyc(); settle();
    check_eq("r_c1_bus_req", {31'h0, bus_req}, 32'h1);
    cyc(); rst_n = 1'b0; data_req = 1'b0; settle();
    check_eq("r_bus_req_zero", {31'h0, bus_req}, 32'h0);
    check_eq("r_bus_addr_zero", bus_addr, 32'h0);
    check_eq("r_inst_rdata_zero", inst_rdata, 32'h0);
    cyc(); rst_n = 1'b1; bus_ack = 1'b1;
    cyc(); bus_ack = 1'b0; settle();
    check_eq("r_no_done_after", {30'h0, inst_done, data_done}, 32'h0);
    check_eq("r_idle_after", {31'h0, bus_req}, 32'h0);
    cyc();

`ifdef MEM_ARB_TIMEOUT_EN
    // Load never acked: bus_req high in cycles 1..4, done+err in cycle 5
    cyc(); data_req = 1'b1; data_we = 1'b0; data_addr = 32'h8000_0040;
    cyc();
    for (int i = 1; i <= 4; i++) begin
      settle();
      check_eq($sformatf("to_c%0d_bus_req", i), {31'h0, bus_req}, 32'h1);
      cyc();
    end
    settle();
    check_eq("to_c5_bus_req", {31'h0, bus_req}, 32'h0);
    check_eq("to_c5_done_err", {30'h0, data_done, bus_err}, 32'h3);
    check_eq("to_c5_data_rdata", data_rdata, 32'h0);
    data_req = 1'b0;
    cyc(); settle();
    check_eq("to_c6_err_pulse", {31'h0, bus_err}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
